// File: rtl/filter_package.sv
// Shared number format for the channel filter input path.
package filter_package;

    localparam int unsigned FILTER_IN_WIDTH = 10;
    localparam int unsigned FILTER_IN_POINT = 6;

    typedef logic signed [FILTER_IN_WIDTH-1:0] FILTER_IN_FORMAT;

endpackage

// File: rtl/tx_package.sv
// Transmit FFE driver types, PRBS7 feedback mask and output saturation helper.
package tx_package;

    import filter_package::*;

    localparam int unsigned TX_NUM_TAPS  = 3;
    localparam int unsigned TX_TAP_WIDTH = 10;

    typedef logic signed [TX_TAP_WIDTH-1:0] FFE_TAP_FORMAT;

    // x^7 + x^6 + 1: feedback from lfsr[6] and lfsr[5]
    localparam logic [6:0] PRBS7_TAPS = 7'h60;

    localparam int FILTER_IN_MAX = (1 <<< (FILTER_IN_WIDTH - 1)) - 1;
    localparam int FILTER_IN_MIN = -(1 <<< (FILTER_IN_WIDTH - 1));

    function automatic FILTER_IN_FORMAT tx_ffe_sat(input int sum);
        if (sum > FILTER_IN_MAX) begin
            return FILTER_IN_FORMAT'(FILTER_IN_MAX);
        end
        if (sum < FILTER_IN_MIN) begin
            return FILTER_IN_FORMAT'(FILTER_IN_MIN);
        end
        return FILTER_IN_FORMAT'(sum);
    endfunction

endpackage

// File: rtl/prbs7_gen.sv
// PRBS7 LFSR; bit_o is the next bit, the register shifts it in when cke_i is high.
module prbs7_gen
    import tx_package::*;
#(
    parameter logic [6:0] SEED = 7'h7F
) (
    input  logic clk,
    input  logic rst,
    input  logic cke_i,
    output logic bit_o
);

    logic [6:0] lfsr_q;
    logic [6:0] lfsr_d;

    assign bit_o = ^(lfsr_q & PRBS7_TAPS);

    always_comb begin
        lfsr_d = lfsr_q;
        if (cke_i) begin
            lfsr_d = {lfsr_q[5:0], bit_o};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/tx_ffe_driver.sv
// Transmit symbol source with N-tap FFE feeding the filter input, one cycle after each UI strobe.
// Optional error injection is enabled by defining TX_ERR_INJECT_EN.
module tx_ffe_driver
    import filter_package::*;
    import tx_package::*;
#(
    parameter int unsigned N_TAPS         = TX_NUM_TAPS,
    parameter int unsigned TAP_WIDTH      = TX_TAP_WIDTH,
    parameter int          TAP_RESET_MAIN = 1 << FILTER_IN_POINT,
    parameter logic [6:0]  PRBS_SEED      = 7'h7F
) (
    input  logic                        clk,
    input  logic                        rst,
`ifdef TX_ERR_INJECT_EN
    input  logic                        err_inject,
    output logic [15:0]                 err_count,
`endif
    input  logic                        time_eq_in,
    input  logic                        src_sel,
    input  logic                        ext_bit,
    input  logic                        tap_we,
    input  logic [$clog2(N_TAPS)-1:0]   tap_addr,
    input  logic signed [TAP_WIDTH-1:0] tap_data,
    input  logic                        tap_commit,
    output logic                        tap_pending,
    output logic                        tx_bit,
    output logic [FILTER_IN_WIDTH-1:0]  out
);

    localparam int unsigned AW    = $clog2(N_TAPS);
    localparam int unsigned CW    = $clog2(N_TAPS + 1);
    localparam int unsigned SUM_W = TAP_WIDTH + AW + 1;

    typedef logic signed [TAP_WIDTH-1:0] tap_t;

    tap_t                  shadow_q [N_TAPS];
    tap_t                  shadow_d [N_TAPS];
    tap_t                  active_q [N_TAPS];
    tap_t                  active_d [N_TAPS];
    logic                  pending_q, pending_d;
    logic                  pend_n;
    logic [N_TAPS-1:0]     hist_q, hist_d;
    logic [CW-1:0]         hist_cnt_q, hist_cnt_d;
    logic                  tx_q, tx_d;
    logic                  strb_q;
    FILTER_IN_FORMAT       out_q, out_d;
    logic signed [SUM_W-1:0] sum;
    logic                  prbs_bit;
    logic                  raw_bit;
    logic                  src_bit;

    prbs7_gen #(
        .SEED (PRBS_SEED)
    ) u_prbs (
        .clk   (clk),
        .rst   (rst),
        .cke_i (time_eq_in & ~src_sel),
        .bit_o (prbs_bit)
    );

    assign raw_bit = src_sel ? ext_bit : prbs_bit;

`ifdef TX_ERR_INJECT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    // Inversion is applied after the LFSR tap-off, so the PRBS sequence itself is untouched
    assign src_bit = raw_bit ^ err_inject;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (time_eq_in && err_inject && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign src_bit = raw_bit;
`endif

    // Commit copies the pre-write shadow; a same-cycle write lands in shadow only
    always_comb begin
        pend_n    = pending_q | tap_commit;
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pend_n;
        if (time_eq_in && pend_n) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (tap_we && (32'(tap_addr) < N_TAPS)) begin
            shadow_d[tap_addr] = tap_data;
        end
    end

    always_comb begin
        hist_d     = hist_q;
        hist_cnt_d = hist_cnt_q;
        tx_d       = tx_q;
        if (time_eq_in) begin
            hist_d[0] = src_bit;
            for (int unsigned k = 1; k < N_TAPS; k++) begin
                hist_d[k] = hist_q[k-1];
            end
            tx_d = src_bit;
            if (hist_cnt_q != CW'(N_TAPS)) begin
                hist_cnt_d = hist_cnt_q + CW'(1);
            end
        end
    end

    // Entries not yet filled since reset contribute nothing
    always_comb begin
        sum = '0;
        for (int unsigned k = 0; k < N_TAPS; k++) begin
            if (k < 32'(hist_cnt_q)) begin
                if (hist_q[k]) begin
                    sum = sum + SUM_W'(active_q[k]);
                end else begin
                    sum = sum - SUM_W'(active_q[k]);
                end
            end
        end
        out_d = tx_ffe_sat(int'(sum));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < N_TAPS; k++) begin
                shadow_q[k] <= (k == 0) ? tap_t'(TAP_RESET_MAIN) : '0;
                active_q[k] <= (k == 0) ? tap_t'(TAP_RESET_MAIN) : '0;
            end
            pending_q  <= 1'b0;
            hist_q     <= '0;
            hist_cnt_q <= '0;
            tx_q       <= 1'b0;
            strb_q     <= 1'b0;
            out_q      <= '0;
        end else begin
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            pending_q  <= pending_d;
            hist_q     <= hist_d;
            hist_cnt_q <= hist_cnt_d;
            tx_q       <= tx_d;
            strb_q     <= time_eq_in;
            if (strb_q) begin
                out_q <= out_d;
            end
        end
    end

    assign out         = out_q;
    assign tx_bit      = tx_q;
    assign tap_pending = pending_q;

endmodule

// File: tb/tb_tx_ffe_driver.sv
// Scoreboard bench for tx_ffe_driver against a queue-based reference of the FFE source.
module tb_tx_ffe_driver;

    logic              clk = 1'b0;
    logic              rst;
    logic              time_eq_in;
    logic              src_sel;
    logic              ext_bit;
    logic              tap_we;
    logic [1:0]        tap_addr;
    logic signed [9:0] tap_data;
    logic              tap_commit;
    logic              tap_pending;
    logic              tx_bit;
    logic signed [9:0] out;
`ifdef TX_ERR_INJECT_EN
    logic              err_inject = 1'b0;
    logic [15:0]       err_count;
`endif

    tx_ffe_driver #(
        .N_TAPS         (3),
        .TAP_WIDTH      (10),
        .TAP_RESET_MAIN (64),
        .PRBS_SEED      (7'h7F)
    ) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef TX_ERR_INJECT_EN
        .err_inject  (err_inject),
        .err_count   (err_count),
`endif
        .time_eq_in  (time_eq_in),
        .src_sel     (src_sel),
        .ext_bit     (ext_bit),
        .tap_we      (tap_we),
        .tap_addr    (tap_addr),
        .tap_data    (tap_data),
        .tap_commit  (tap_commit),
        .tap_pending (tap_pending),
        .tx_bit      (tx_bit),
        .out         (out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: bit history as a list (newest first), tap arrays, pending flag
    int m_lfsr;
    int m_hist[$];
    int m_shadow[3];
    int m_active[3];
    bit m_pending;
    bit m_tx;
    int exp_q[$];

    function automatic int ref_sat(int s);
        if (s > 511) return 511;
        if (s < -512) return -512;
        return s;
    endfunction

    function automatic int ffe_now();
        int s = 0;
        for (int i = 0; i < m_hist.size(); i++) begin
            s += (m_hist[i] != 0 ? 1 : -1) * m_active[i];
        end
        return ref_sat(s);
    endfunction

    task automatic check(string nm, int act, int ex);
        n_cmp++;
        if (act != ex) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, ex);
        end
    endtask

    task automatic model_edge();
        bit pend_n;
        int b;
        if (rst) begin
            m_lfsr = 7'h7F;
            m_hist.delete();
            m_tx = 0;
            m_shadow = '{64, 0, 0};
            m_active = '{64, 0, 0};
            m_pending = 0;
            exp_q.delete();
            return;
        end
        pend_n = m_pending | tap_commit;
        if (time_eq_in && pend_n) begin
            m_active = m_shadow;
            m_pending = 0;
        end else begin
            m_pending = pend_n;
        end
        if (tap_we && tap_addr < 3) m_shadow[tap_addr] = int'(tap_data);
        if (time_eq_in) begin
            if (src_sel) begin
                b = ext_bit;
            end else begin
                b = ((m_lfsr >> 6) ^ (m_lfsr >> 5)) & 1;
                m_lfsr = ((m_lfsr << 1) | b) & 127;
            end
            m_hist.push_front(b);
            if (m_hist.size() > 3) void'(m_hist.pop_back());
            m_tx = b[0];
            exp_q.push_back(ffe_now());
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic quiet();
        rst = 0; time_eq_in = 0; tap_we = 0; tap_commit = 0;
    endtask

    task automatic check_out_neg(string nm, int ex);
        @(negedge clk);
        check(nm, int'(out), ex);
    endtask

    task automatic wr_tap(int a, int v);
        tap_we = 1; tap_addr = 2'(a); tap_data = 10'(v);
        tick();
        tap_we = 0;
    endtask

    task automatic strobe_ext(bit b);
        time_eq_in = 1; src_sel = 1; ext_bit = b;
        tick();
        time_eq_in = 0;
        tick();
    endtask

    // Monitor: tracks the strobe delay on its own, pops one expectation per update
    bit started = 0;
    bit strb_d  = 0;
    bit upd     = 0;
    int hold    = 0;

    always @(posedge clk) begin
        upd    = strb_d && !rst;
        strb_d = time_eq_in && !rst;
        if (rst) begin
            started = 1;
            hold    = 0;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            if (upd) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_underflow at %0t: update with no expectation queued", $time);
                end else begin
                    hold = exp_q.pop_front();
                end
            end
            check("out", int'(out), hold);
            check("tx_bit", int'(tx_bit), int'(m_tx));
            check("tap_pending", int'(tap_pending), int'(m_pending));
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        quiet();
        src_sel = 0; ext_bit = 0; tap_addr = 0; tap_data = 0;
        rst = 1;
        tick(); tick();
        rst = 0;
        check_out_neg("reset_out", 0);

        // PRBS7 with default taps, strobe every 4 cycles
        src_sel = 0;
        for (int i = 0; i < 130; i++) begin
            time_eq_in = 1;
            tick();
            time_eq_in = 0;
            tick(); tick(); tick();
        end

        // Reset, taps {64,-16,8}, commit coincident with first strobe
        rst = 1; tick(); rst = 0;
        wr_tap(0, 64); wr_tap(1, -16); wr_tap(2, 8);
        tap_commit = 1; time_eq_in = 1; src_sel = 1; ext_bit = 1;
        tick();
        tap_commit = 0; time_eq_in = 0;
        @(negedge clk);
        check("coincident_commit_pending", int'(tap_pending), 0);
        tick();
        check_out_neg("first_sym", 64);
        strobe_ext(1);
        check_out_neg("second_sym", 48);
        strobe_ext(0);
        check_out_neg("third_sym", -72);

        // Mid-UI commit stays pending until next strobe
        wr_tap(0, 100);
        tap_commit = 1; tick(); tap_commit = 0;
        @(negedge clk);
        check("midui_pending", int'(tap_pending), 1);
        tick(); tick();
        check_out_neg("prior_ui_kept", -72);
        strobe_ext(1);
        @(negedge clk);
        check("pending_cleared", int'(tap_pending), 0);
        check("new_taps_out", int'(out), 124);

        // Commit with strobe plus same-cycle shadow write
        wr_tap(1, -32);
        tap_commit = 1; time_eq_in = 1; ext_bit = 0;
        tap_we = 1; tap_addr = 2; tap_data = 10'sd5;
        tick();
        quiet();
        tick();
        check_out_neg("commit_with_write", -140);

        // Saturation
        wr_tap(0, 511); wr_tap(1, 511); wr_tap(2, 511);
        tap_commit = 1; tick(); tap_commit = 0;
        strobe_ext(1); strobe_ext(1); strobe_ext(1);
        check_out_neg("saturate_max", 511);

        // Back-to-back strobes with reset on the second
        rst = 1; tick(); rst = 0;
        time_eq_in = 1; src_sel = 1; ext_bit = 0;
        tick();
        rst = 1;
        tick();
        check_out_neg("reset_discard", 0);
        rst = 0; time_eq_in = 1; ext_bit = 1;
        tick();
        time_eq_in = 0;
        tick();
        check_out_neg("post_reset_first", 64);
        time_eq_in = 1;
        for (int i = 0; i < 3; i++) begin
            ext_bit = 1'(i & 1);
            tick();
        end
        time_eq_in = 0;
        tick(); tick();

        // Randomized traffic
        for (int i = 0; i < 700; i++) begin
            rst        = ($urandom_range(0, 199) == 0);
            time_eq_in = ($urandom_range(0, 99) < 40);
            src_sel    = ($urandom_range(0, 3) == 0) ? ~src_sel : src_sel;
            ext_bit    = 1'($urandom);
            tap_we     = ($urandom_range(0, 3) == 0);
            tap_addr   = 2'($urandom);
            tap_data   = 10'($urandom);
            tap_commit = ($urandom_range(0, 9) == 0);
            tick();
        end
        quiet();
        tick(); tick(); tick();
        @(negedge clk);
        check("sb_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
